// File: rtl/loopback_checker.sv
// Loopback checker: drives a known word sequence on tx_* and checks its return on rx_* after any loop delay.
// Define LOOPBACK_CHECKER_PRBS_EN to use a 16-bit Galois LFSR sequence instead of an incrementing count.
module loopback_checker #(
  parameter int WIDTH        = 8,
  parameter int LENGTH       = 256,
  parameter int SYNC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [15:0]      err_count
);

`ifdef LOOPBACK_CHECKER_PRBS_EN
  localparam int GEN_W = 16;
  localparam logic [GEN_W-1:0] SEED = 16'hACE1;
`else
  localparam int GEN_W = WIDTH;
  localparam logic [GEN_W-1:0] SEED = '0;
`endif

  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int SIL_W = $clog2(SYNC_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);
  localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RX, S_CHECK, S_DONE} state_t;

  function automatic logic [GEN_W-1:0] f_gen_next(input logic [GEN_W-1:0] s);
`ifdef LOOPBACK_CHECKER_PRBS_EN
    return {1'b0, s[GEN_W-1:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
`else
    return s + GEN_W'(1);
`endif
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t           r_state;
  logic [GEN_W-1:0] r_tx_gen;
  logic [CNT_W-1:0] r_tx_cnt;
  logic             r_tx_valid;
  logic [GEN_W-1:0] r_rx_gen;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [SIL_W-1:0] r_sil;
  logic [15:0]      r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;

  logic             w_active;
  logic             w_launch;
  logic             w_mismatch;
  logic [15:0]      w_err_next;

  assign w_active   = (r_state == S_WAIT_RX) || (r_state == S_CHECK);
  assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mismatch = rx_data != r_rx_gen[WIDTH-1:0];
  assign w_err_next = (w_active && rx_valid && w_mismatch) ? f_sat_inc(r_err) : r_err;

  // Transmitter: free-running burst of LENGTH words, independent of the receive side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_gen   <= '0;
      r_tx_cnt   <= '0;
    end else if (w_launch) begin
      r_tx_valid <= 1'b1;
      r_tx_gen   <= SEED;
      r_tx_cnt   <= '0;
    end else if (r_tx_valid) begin
      if (r_tx_cnt == LAST_IDX) begin
        r_tx_valid <= 1'b0;
      end else begin
        r_tx_gen <= f_gen_next(r_tx_gen);
        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end
    end
  end

  // Receiver FSM: own expected index, so the loop latency never has to be known
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rx_gen  <= '0;
      r_rx_cnt  <= '0;
      r_sil     <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_WAIT_RX;
            r_rx_gen  <= SEED;
            r_rx_cnt  <= '0;
            r_sil     <= '0;
            r_err     <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_WAIT_RX, S_CHECK: begin
          r_err <= w_err_next;
          if (rx_valid) begin
            r_sil    <= '0;
            r_rx_gen <= f_gen_next(r_rx_gen);
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            if (r_rx_cnt == LAST_IDX) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 16'd0);
            end else begin
              r_state <= S_CHECK;
            end
          end else if (r_sil == SIL_LAST) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_sil <= r_sil + SIL_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data   = r_tx_gen[WIDTH-1:0];
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign err_count = r_err;

endmodule

// File: tb/tb_loopback_checker.sv
// Directed bench for loopback_checker (WIDTH=8, LENGTH=16, SYNC_TIMEOUT=8) with selectable external loop models.
module tb_loopback_checker;
  localparam int W = 8;
  localparam int L = 16;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         done;
  logic         pass;
  logic         timeout;
  logic [15:0]  err_count;

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  int txn    = 0;

  logic [W-1:0] dl_d [1:7];
  logic         dl_v [1:7];

  loopback_checker #(.WIDTH(W), .LENGTH(L), .SYNC_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl_d[1] <= tx_data;
    dl_v[1] <= tx_valid;
    for (int i = 2; i <= 7; i++) begin
      dl_d[i] <= dl_d[i-1];
      dl_v[i] <= dl_v[i-1];
    end
    if (start) txn <= 0;
    else if (tx_valid) txn <= txn + 1;
  end

  // External loop models selected by mode
  always_comb begin
    rx_data  = tx_data;
    rx_valid = tx_valid;
    case (mode)
      1: begin rx_data = dl_d[3]; rx_valid = dl_v[3]; end
      2: rx_data = tx_data & 8'hF7;
      3: rx_valid = 1'b0;
      4: rx_valid = tx_valid && (txn < 5);
      5: begin rx_data = dl_d[7]; rx_valid = dl_v[7]; end
      6: rx_valid = tx_valid && (txn >= 10);
      default: ;
    endcase
  end

  function automatic logic [7:0] f_word(input int n);
`ifdef LOOPBACK_CHECKER_PRBS_EN
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < n; i++) s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    return s[7:0];
`else
    return 8'(n);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  typedef struct {
    int mode;
    int exp_n;
    int exp_err;
    int exp_pass;
    int exp_to;
  } vec_t;

  // inj_kind 1: extra start pulse at cycle inj_cyc (must be ignored)
  task automatic run_row(input vec_t v, input string tag, input int inj_cyc, input int inj_kind);
    int k;
    int got_n;
    k     = 0;
    got_n = 0;
    mode  = v.mode;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_c1"}, 32'(busy), 1);
    check({tag, "_done_c1"}, 32'(done), 0);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      start = 1'b0;
      if (tx_valid) begin
        check($sformatf("%s_tx%0d", tag, k), 32'(tx_data), 32'(f_word(k)));
        k++;
      end
      if (done && got_n == 0) got_n = cyc;
      if (got_n != 0 && !tx_valid) break;
      if (inj_kind == 1 && cyc == inj_cyc) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(got_n), 32'(v.exp_n));
    check({tag, "_tx_words"}, 32'(k), 32'(L));
    check({tag, "_err_count"}, 32'(err_count), 32'(v.exp_err));
    check({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
    check({tag, "_timeout"}, 32'(timeout), 32'(v.exp_to));
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_done_held"}, 32'(done), 1);
  endtask

  vec_t tbl [7];
  int   e_bit3;

  initial begin
    logic [7:0] w;
    e_bit3 = 0;
    for (int i = 0; i < L; i++) begin
      w = f_word(i);
      if (w[3]) e_bit3++;
    end
    tbl[0] = '{0, 17, 0,      1,               0};
    tbl[1] = '{1, 20, 0,      1,               0};
    tbl[2] = '{2, 17, e_bit3, (e_bit3 == 0),   0};
    tbl[3] = '{3,  9, 0,      0,               1};
    tbl[4] = '{4, 14, 0,      0,               1};
    tbl[5] = '{5, 24, 0,      1,               0};
    tbl[6] = '{6,  9, 0,      0,               1};

    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    #12;
    check_all_zero("reset");
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int r = 0; r < 7; r++) begin
      run_row(tbl[r], $sformatf("row%0d", r), 0, 0);
      repeat (10) @(negedge clk);
    end

    run_row(tbl[0], "restart_ignored", 5, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a run, then a clean rerun
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_word5", 32'(tx_data), 32'(f_word(5)));
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("post_rst_idle");
    run_row(tbl[0], "after_rst", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
